traffic_light_phase_ctrl: RTL and testbench



---
 rtl/traffic_light_phase_ctrl.sv | 134 +++++++++++++
 tb/tb_traffic_light_phase_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_phase_ctrl.sv
// traffic_light_phase_ctrl
// Single-approach traffic-light phase sequencer: LEFT -> GREEN -> YELLOW -> RED
// with per-phase durations, selectable start phase, optional left-arrow phase
// and an emergency all-stop that resumes exactly where it was interrupted.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   emergency    all-stop request, sampled on rising clk
//   out[3:0]     lamps: [3] left arrow, [2] green, [1] yellow, [0] red
//   phase[2:0]   0 LEFT, 1 GREEN, 2 YELLOW, 3 RED, 4 ALLSTOP
//   allstop      high while phase == ALLSTOP
//   cycle_start  one-cycle pulse on the first cycle of a new pass
module traffic_light_phase_ctrl #(
  parameter int unsigned LEFT_TICKS   = 5,
  parameter int unsigned GREEN_TICKS  = 10,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned RED_TICKS    = 18,
  parameter int unsigned START_PHASE  = 0,
  parameter int unsigned LEFT_EN      = 1,
  parameter int unsigned ALLSTOP_MIN  = 4,
  parameter int unsigned CNT_W        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  output logic [3:0] out,
  output logic [2:0] phase,
  output logic       allstop,
  output logic       cycle_start
);

  typedef enum logic [2:0] {
    PH_LEFT    = 3'd0,
    PH_GREEN   = 3'd1,
    PH_YELLOW  = 3'd2,
    PH_RED     = 3'd3,
    PH_ALLSTOP = 3'd4
  } phase_e;

  localparam logic [CNT_W-1:0] LEFT_LAST    = CNT_W'(LEFT_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST   = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] RED_LAST     = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLSTOP_LAST = CNT_W'(ALLSTOP_MIN - 1);

  // A LEFT start is meaningless without the left phase; start in GREEN instead.
  localparam phase_e RESET_PH = (START_PHASE == 0 && LEFT_EN == 0) ?
                                PH_GREEN : phase_e'(3'(START_PHASE));

  phase_e           phase_q;
  phase_e           save_ph_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] save_cnt_q;
  logic             cs_q;

  logic [CNT_W-1:0] last_cnt_d;
  phase_e           next_ph_d;

  always_comb begin
    last_cnt_d = '0;
    next_ph_d  = PH_RED;
    case (phase_q)
      PH_LEFT:   begin last_cnt_d = LEFT_LAST;   next_ph_d = PH_GREEN;  end
      PH_GREEN:  begin last_cnt_d = GREEN_LAST;  next_ph_d = PH_YELLOW; end
      PH_YELLOW: begin last_cnt_d = YELLOW_LAST; next_ph_d = PH_RED;    end
      PH_RED:    begin
        last_cnt_d = RED_LAST;
        next_ph_d  = (LEFT_EN != 0) ? PH_LEFT : PH_GREEN;
      end
      default:   begin last_cnt_d = '0;          next_ph_d = PH_RED;    end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= RESET_PH;
      cnt_q      <= '0;
      save_ph_q  <= PH_LEFT;
      save_cnt_q <= '0;
      cs_q       <= 1'b0;
    end else begin
      cs_q <= 1'b0;
      case (phase_q)
        PH_LEFT, PH_GREEN, PH_YELLOW, PH_RED: begin
          // Emergency wins over a due transition: the pre-transition
          // phase and un-incremented count are what get replayed.
          if (emergency) begin
            save_ph_q  <= phase_q;
            save_cnt_q <= cnt_q;
            phase_q    <= PH_ALLSTOP;
            cnt_q      <= '0;
          end else if (cnt_q == last_cnt_d) begin
            phase_q <= next_ph_d;
            cnt_q   <= '0;
            // Leaving RED always starts a new pass (LEFT, or GREEN if no LEFT).
            cs_q    <= (phase_q == PH_RED);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PH_ALLSTOP: begin
          if (cnt_q == ALLSTOP_LAST) begin
            if (!emergency) begin
              phase_q <= save_ph_q;
              cnt_q   <= save_cnt_q;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          phase_q <= PH_RED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    out = 4'b0001;
    case (phase_q)
      PH_LEFT:   out = 4'b1001;
      PH_GREEN:  out = 4'b0100;
      PH_YELLOW: out = 4'b0010;
      default:   out = 4'b0001;
    endcase
  end

  assign phase       = phase_q;
  assign allstop     = (phase_q == PH_ALLSTOP);
  assign cycle_start = cs_q;

endmodule

// File: tb/tb_traffic_light_phase_ctrl.sv
// Directed bench for traffic_light_phase_ctrl: default instance, a RED-start
// instance and a no-left-arrow instance share clock, reset and emergency.
module tb_traffic_light_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       emergency = 1'b0;

  logic [3:0] d_out, r_out, n_out;
  logic [2:0] d_ph, r_ph, n_ph;
  logic       d_as, r_as, n_as;
  logic       d_cs, r_cs, n_cs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  traffic_light_phase_ctrl u_def (
    .clk(clk), .rst(rst), .emergency(emergency),
    .out(d_out), .phase(d_ph), .allstop(d_as), .cycle_start(d_cs)
  );

  traffic_light_phase_ctrl #(.START_PHASE(3)) u_red (
    .clk(clk), .rst(rst), .emergency(emergency),
    .out(r_out), .phase(r_ph), .allstop(r_as), .cycle_start(r_cs)
  );

  traffic_light_phase_ctrl #(.LEFT_EN(0)) u_nol (
    .clk(clk), .rst(rst), .emergency(emergency),
    .out(n_out), .phase(n_ph), .allstop(n_as), .cycle_start(n_cs)
  );

  // Expected lamps for default timing at cycle k of an undisturbed run.
  function automatic logic [3:0] def_lamp(input int k);
    int m;
    m = k % 36;
    if (m < 5)       return 4'b1001;
    else if (m < 15) return 4'b0100;
    else if (m < 18) return 4'b0010;
    else             return 4'b0001;
  endfunction

  function automatic logic [3:0] nol_lamp(input int k);
    int m;
    m = k % 31;
    if (m < 10)      return 4'b0100;
    else if (m < 13) return 4'b0010;
    else             return 4'b0001;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the releasing edge: cycle 0 of a run.
  task automatic do_reset();
    rst = 1'b1;
    emergency = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    emergency = 1'b0;
    tick();
    vectors++;
    if (d_out !== 4'b1001 || d_ph !== 3'd0 || d_as !== 1'b0 || d_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_def: out=%b ph=%0d as=%b cs=%b, want 1001/0/0/0", d_out, d_ph, d_as, d_cs);
    end
    vectors++;
    if (r_out !== 4'b0001 || r_ph !== 3'd3 || r_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_red: out=%b ph=%0d cs=%b, want 0001/3/0", r_out, r_ph, r_cs);
    end
    vectors++;
    if (n_out !== 4'b0100 || n_ph !== 3'd1 || n_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_noleft: out=%b ph=%0d cs=%b, want 0100/1/0", n_out, n_ph, n_cs);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    for (int k = 0; k < 73; k++) begin
      vectors++;
      if (d_out !== def_lamp(k) || d_as !== 1'b0) begin
        miscompares++;
        $display("FAIL seq_out k=%0d: out=%b as=%b, want %b/0", k, d_out, d_as, def_lamp(k));
      end
      if (k != 0) begin
        vectors++;
        if (d_cs !== ((k % 36) == 0)) begin
          miscompares++;
          $display("FAIL seq_cs k=%0d: cs=%b, want %b", k, d_cs, ((k % 36) == 0));
        end
      end
      tick();
    end
  endtask

  task automatic test_start_red();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      logic [3:0] e_out;
      logic       e_cs;
      e_out = (k < 18) ? 4'b0001 : 4'b1001;
      e_cs  = (k == 18);
      vectors++;
      if (r_out !== e_out || (k > 0 && r_cs !== e_cs)) begin
        miscompares++;
        $display("FAIL startred k=%0d: out=%b cs=%b, want %b/%b", k, r_out, r_cs, e_out, e_cs);
      end
      tick();
    end
  endtask

  task automatic test_emergency_pulse();
    do_reset();
    repeat (9) tick();             // k=9: GREEN, cnt=4
    emergency = 1'b1;
    tick();                         // k=10: ALLSTOP cnt=0
    emergency = 1'b0;
    for (int k = 10; k < 21; k++) begin
      logic [3:0] e_out;
      logic [2:0] e_ph;
      logic       e_as;
      if (k < 14)      begin e_out = 4'b0001; e_ph = 3'd4; e_as = 1'b1; end
      else if (k < 20) begin e_out = 4'b0100; e_ph = 3'd1; e_as = 1'b0; end
      else             begin e_out = 4'b0010; e_ph = 3'd2; e_as = 1'b0; end
      vectors++;
      if (d_out !== e_out || d_ph !== e_ph || d_as !== e_as || d_cs !== 1'b0) begin
        miscompares++;
        $display("FAIL emg_pulse k=%0d: out=%b ph=%0d as=%b cs=%b, want %b/%0d/%b/0",
                 k, d_out, d_ph, d_as, d_cs, e_out, e_ph, e_as);
      end
      tick();
    end
  endtask

  task automatic test_emergency_held();
    do_reset();
    repeat (35) tick();            // k=35: RED, cnt=17
    emergency = 1'b1;
    for (int k = 36; k < 49; k++) begin
      tick();
      if (k == 45) emergency = 1'b0;
      begin
        logic [3:0] e_out;
        logic [2:0] e_ph;
        logic       e_cs;
        e_cs = 1'b0;
        if (k < 46)       begin e_out = 4'b0001; e_ph = 3'd4; end
        else if (k == 46) begin e_out = 4'b0001; e_ph = 3'd3; end
        else              begin e_out = 4'b1001; e_ph = 3'd0; e_cs = (k == 47); end
        vectors++;
        if (d_out !== e_out || d_ph !== e_ph || d_as !== (e_ph == 3'd4) || d_cs !== e_cs) begin
          miscompares++;
          $display("FAIL emg_held k=%0d: out=%b ph=%0d as=%b cs=%b, want %b/%0d/%b/%b",
                   k, d_out, d_ph, d_as, d_cs, e_out, e_ph, (e_ph == 3'd4), e_cs);
        end
      end
    end
  endtask

  task automatic test_no_left();
    do_reset();
    for (int k = 0; k < 63; k++) begin
      vectors++;
      if (n_out !== nol_lamp(k)) begin
        miscompares++;
        $display("FAIL noleft_out k=%0d: out=%b, want %b", k, n_out, nol_lamp(k));
      end
      if (k != 0) begin
        vectors++;
        if (n_cs !== ((k % 31) == 0)) begin
          miscompares++;
          $display("FAIL noleft_cs k=%0d: cs=%b, want %b", k, n_cs, ((k % 31) == 0));
        end
      end
      tick();
    end
  endtask

  task automatic test_rst_mid_allstop();
    do_reset();
    repeat (2) tick();             // k=2: LEFT cnt=2
    emergency = 1'b1;
    repeat (2) tick();             // two cycles into ALLSTOP
    vectors++;
    if (d_as !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: as=%b, want 1", d_as);
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (d_ph !== 3'd0 || d_out !== 4'b1001 || d_as !== 1'b0 || r_ph !== 3'd3) begin
      miscompares++;
      $display("FAIL rstmid_async: ph=%0d out=%b as=%b red_ph=%0d, want 0/1001/0/3",
               d_ph, d_out, d_as, r_ph);
    end
    emergency = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      vectors++;
      if (d_out !== def_lamp(k) || d_as !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_seq k=%0d: out=%b as=%b, want %b/0", k, d_out, d_as, def_lamp(k));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_start_red();
    test_emergency_pulse();
    test_emergency_held();
    test_no_left();
    test_rst_mid_allstop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
